camo_key_loader: RTL and testbench

- Serial key-delivery block for camouflaged/obfuscated netlists. It drives the 2-bit-per-cell key bus (D_0..D_{2N-1}) that each obfuscated cell decodes as: 00 = pass-through, 01 = invert, 10 = constant 1, 11 = constant 0.
- Accepts key codes one cell per beat over a valid/ready stream and assembles them in a shadow register.
- Commits the shadow register atomically to the key bus and then locks until explicitly cleared.
- Sits between the key source (tamper-proof memory / test port) and the obfuscated combinational core.

---
 rtl/camo_key_pkg.sv | 23 ++
 rtl/camo_key_shadow.sv | 46 ++++
 rtl/camo_key_loader.sv | 143 ++++++++++++++
 tb/tb_camo_key_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camo_key_pkg.sv
// Shared types and constants for the camouflaged-netlist key loader.
// Cell codes are the 2-bit values each obfuscated cell decodes.
package camo_key_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCommit,
    StLocked,
    StError
  } key_state_e;

  localparam logic [1:0] CODE_PASS = 2'b00;
  localparam logic [1:0] CODE_INV  = 2'b01;
  localparam logic [1:0] CODE_ONE  = 2'b10;
  localparam logic [1:0] CODE_ZERO = 2'b11;

  // Index width for a counter spanning n beats, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/camo_key_shadow.sv
// Indexed shadow register holding the key while it is being assembled.
// Preset loads every cell with the safe reset code; preset wins over a write.
module camo_key_shadow
  import camo_key_pkg::*;
#(
  parameter int unsigned NUM_CELLS  = 5,
  parameter logic [1:0]  RESET_CODE = CODE_ONE,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   preset_i,
  input  logic                   wr_en_i,
  input  logic [CNT_W-1:0]       wr_idx_i,
  input  logic [1:0]             wr_data_i,
  output logic [2*NUM_CELLS-1:0] shadow_o
);

  localparam logic [2*NUM_CELLS-1:0] PresetVal = {NUM_CELLS{RESET_CODE}};

  logic [2*NUM_CELLS-1:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (preset_i) begin
      shadow_d = PresetVal;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
        if (wr_idx_i == CNT_W'(i)) begin
          shadow_d[2*i +: 2] = wr_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= PresetVal;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/camo_key_loader.sv
// Serial key loader: assembles per-cell codes from a valid/ready stream, then
// commits them atomically to the key bus and locks. CAMO_KEY_PARITY_EN adds a parity beat.
module camo_key_loader
  import camo_key_pkg::*;
#(
  parameter int unsigned NUM_CELLS  = 5,
  parameter logic [1:0]  RESET_CODE = CODE_ONE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [1:0]             key_data,
  input  logic                   key_last,
  output logic [2*NUM_CELLS-1:0] key_bus,
  output logic                   key_locked,
  output logic                   key_err
);

`ifdef CAMO_KEY_PARITY_EN
  localparam int unsigned NumBeats = NUM_CELLS + 1;
`else
  localparam int unsigned NumBeats = NUM_CELLS;
`endif
  localparam int unsigned            CntW     = cnt_w(NumBeats);
  localparam logic [CntW-1:0]        LastIdx  = CntW'(NumBeats - 1);
  localparam logic [2*NUM_CELLS-1:0] ResetBus = {NUM_CELLS{RESET_CODE}};

  key_state_e             state_q;
  logic [CntW-1:0]        cnt_q;
  logic [2*NUM_CELLS-1:0] key_bus_q;
  logic                   key_locked_q;
  logic                   key_err_q;
  logic                   key_ready_q;

  logic                   beat;
  logic                   parity_ok;
  logic                   shadow_we;
  logic                   shadow_preset;
  logic [2*NUM_CELLS-1:0] shadow;

  assign beat          = key_valid && key_ready_q;
  assign shadow_preset = clear || ((state_q == StIdle) && start);

`ifdef CAMO_KEY_PARITY_EN
  // The final beat carries even parity over every shadow bit, not a cell code.
  assign parity_ok = (key_data[1] == 1'b0) && (key_data[0] == ^shadow);
  assign shadow_we = beat && !clear && (cnt_q != LastIdx);
`else
  assign parity_ok = 1'b1;
  assign shadow_we = beat && !clear;
`endif

  camo_key_shadow #(
    .NUM_CELLS  (NUM_CELLS),
    .RESET_CODE (RESET_CODE),
    .CNT_W      (CntW)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .preset_i  (shadow_preset),
    .wr_en_i   (shadow_we),
    .wr_idx_i  (cnt_q),
    .wr_data_i (key_data),
    .shadow_o  (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      key_bus_q    <= ResetBus;
      key_locked_q <= 1'b0;
      key_err_q    <= 1'b0;
      key_ready_q  <= 1'b0;
    end else if (clear) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      key_bus_q    <= ResetBus;
      key_locked_q <= 1'b0;
      key_err_q    <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            key_ready_q <= 1'b1;
          end
        end
        StLoad: begin
          if (beat) begin
            if (cnt_q == LastIdx) begin
              key_ready_q <= 1'b0;
              if (key_last && parity_ok) begin
                state_q <= StCommit;
              end else begin
                state_q   <= StError;
                key_err_q <= 1'b1;
                key_bus_q <= ResetBus;
              end
            end else if (key_last) begin
              state_q     <= StError;
              key_err_q   <= 1'b1;
              key_bus_q   <= ResetBus;
              key_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCommit: begin
          // Whole-key transfer in one edge so the core never sees a partial key.
          key_bus_q    <= shadow;
          key_locked_q <= 1'b1;
          state_q      <= StLocked;
        end
        StLocked: begin
          key_ready_q <= 1'b0;
        end
        StError: begin
          key_bus_q    <= ResetBus;
          key_locked_q <= 1'b0;
          key_err_q    <= 1'b1;
          key_ready_q  <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          key_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_bus    = key_bus_q;
  assign key_locked = key_locked_q;
  assign key_err    = key_err_q;
  assign key_ready  = key_ready_q;

endmodule

// File: tb/tb_camo_key_loader.sv
// Directed-plus-random bench for camo_key_loader against a session-level model.
// Compile with CAMO_KEY_PARITY_EN to exercise the parity-beat variant.
module tb_camo_key_loader;
  import camo_key_pkg::*;

  localparam int unsigned N  = 5;
  localparam logic [1:0]  RC = CODE_ONE;
`ifdef CAMO_KEY_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam int              OW        = 3 + 2 * N;
  localparam logic [2*N-1:0]  RESET_BUS = {N{RC}};

  logic           clk       = 1'b0;
  logic           rst       = 1'b0;
  logic           clear     = 1'b0;
  logic           start     = 1'b0;
  logic           key_valid = 1'b0;
  logic           key_last  = 1'b0;
  logic [1:0]     key_data  = 2'b00;
  logic           key_ready;
  logic           key_locked;
  logic           key_err;
  logic [2*N-1:0] key_bus;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] codes [N];

  camo_key_loader #(
    .NUM_CELLS  (N),
    .RESET_CODE (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .start      (start),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .key_last   (key_last),
    .key_bus    (key_bus),
    .key_locked (key_locked),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected key: cell i occupies bits [2i+1:2i].
  function automatic logic [2*N-1:0] model_key();
    logic [2*N-1:0] k;
    for (int i = 0; i < N; i++) k[2*i +: 2] = codes[i];
    return k;
  endfunction

  function automatic logic [1:0] beat_data(input int i);
    if (i < N) return codes[i];
    return {1'b0, ^model_key()};
  endfunction

  // Snapshot compare of {ready, locked, err, bus}.
  task automatic check(input string tag, input logic [OW-1:0] exp);
    logic [OW-1:0] obs;
    obs = {key_ready, key_locked, key_err, key_bus};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed r/l/e/bus=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check(tag, {3'b000, RESET_BUS});
  endtask

  task automatic send_beat(input logic [1:0] d, input logic l, input int gap);
    int n;
    n = 0;
    key_valid = 1'b0;
    repeat (gap) tick();
    key_valid = 1'b1;
    key_data  = d;
    key_last  = l;
    while (!key_ready && n < 16) begin
      tick();
      n++;
    end
    check("beat_ready", {3'b100, RESET_BUS});
    tick();
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic send_session(input int last_at, input int nbeats, input int max_gap);
    for (int i = 0; i < nbeats; i++)
      send_beat(beat_data(i), (i == last_at), $urandom_range(0, max_gap));
  endtask

  task automatic expect_outcome(input string tag, input bit ok);
    if (ok) begin
      check({tag, "_commit"}, {3'b000, RESET_BUS});
      tick();
      check({tag, "_locked"}, {3'b010, model_key()});
    end else begin
      check({tag, "_err"}, {3'b001, RESET_BUS});
    end
  endtask

  task automatic hold_valid(input int cycles);
    key_valid = 1'b1;
    key_last  = 1'b1;
    key_data  = 2'($urandom);
    repeat (cycles) tick();
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic random_codes();
    for (int i = 0; i < N; i++) codes[i] = 2'($urandom);
  endtask

  initial begin
    int kind;
    int last_at;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_async", {3'b000, RESET_BUS});
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset_idle", {3'b000, RESET_BUS});

    // Nominal load with the reference pattern 00,01,10,11,00.
    codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10; codes[3] = 2'b11; codes[4] = 2'b00;
    pulse_start();
    check("load_ready", {3'b100, RESET_BUS});
    send_session(NB - 1, NB, 0);
    expect_outcome("nominal", 1'b1);
`ifndef CAMO_KEY_PARITY_EN
    check("nominal_pattern", {3'b010, 10'b00_11_10_01_00});
`endif

    // Second start while locked, followed by beats, must not disturb the key.
    pulse_start();
    hold_valid(4);
    check("locked_ignore", {3'b010, model_key()});
    do_clear("clear_locked");

    // Early last.
    random_codes();
    pulse_start();
    send_session(1, 2, 0);
    expect_outcome("early_last", 1'b0);
    hold_valid(3);
    check("early_hold", {3'b001, RESET_BUS});
    do_clear("clear_err");

    // Missing last.
    random_codes();
    pulse_start();
    send_session(-1, NB, 0);
    expect_outcome("missing_last", 1'b0);
    hold_valid(3);
    check("missing_hold", {3'b001, RESET_BUS});
    do_clear("clear_missing");

    // Backpressure: idle gaps between beats.
    random_codes();
    pulse_start();
    send_session(NB - 1, NB, 2);
    expect_outcome("gaps", 1'b1);
    do_clear("clear_gaps");

    // clear coincident with the final beat wins over the beat.
    random_codes();
    pulse_start();
    for (int i = 0; i < NB - 1; i++) send_beat(beat_data(i), 1'b0, 0);
    key_valid = 1'b1;
    key_last  = 1'b1;
    key_data  = beat_data(NB - 1);
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    key_valid = 1'b0;
    key_last  = 1'b0;
    check("clear_final", {3'b000, RESET_BUS});
    tick();
    tick();
    check("clear_final_nocommit", {3'b000, RESET_BUS});

    // Asynchronous reset mid-LOAD after three beats.
    random_codes();
    pulse_start();
    for (int i = 0; i < 3; i++) send_beat(beat_data(i), 1'b0, 0);
    #2 rst = 1'b1;
    #1 check("rst_midload", {3'b000, RESET_BUS});
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("rst_settled", {3'b000, RESET_BUS});

`ifdef CAMO_KEY_PARITY_EN
    // Corrupted parity bit on the final beat.
    random_codes();
    pulse_start();
    for (int i = 0; i < N; i++) send_beat(beat_data(i), 1'b0, 0);
    send_beat(beat_data(N) ^ 2'b01, 1'b1, 0);
    expect_outcome("bad_parity", 1'b0);
    do_clear("clear_parity");
`endif

    // Random sessions: nominal, early last or missing last.
    for (int s = 0; s < 15; s++) begin
      random_codes();
      kind = $urandom_range(0, 2);
      pulse_start();
      if (kind == 0) begin
        send_session(NB - 1, NB, 2);
        expect_outcome("rand_ok", 1'b1);
      end else if (kind == 1) begin
        last_at = $urandom_range(0, NB - 2);
        send_session(last_at, last_at + 1, 2);
        expect_outcome("rand_early", 1'b0);
      end else begin
        send_session(-1, NB, 2);
        expect_outcome("rand_missing", 1'b0);
      end
      do_clear("rand_clear");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
